// File: rtl/jrb8_spi_pkg.sv
// jrb8_spi_pkg: command codes and FSM states shared by the SPI memory responder.
package jrb8_spi_pkg;

    localparam logic [7:0] CMD_READ  = 8'h03;
    localparam logic [7:0] CMD_WRITE = 8'h02;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR_HI,
        ADDR_LO,
        READ_DATA,
        WRITE_DATA,
        IGNORE
    } spi_resp_state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: multi-flop synchronizer with one-cycle rise/fall pulses on the synchronized level.
module spi_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= (sync_q << 1) | STAGES'(d);
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign q    = sync_q[STAGES-1];
    assign rise = q & ~prev_q;
    assign fall = ~q & prev_q;

endmodule

// File: rtl/spi_mem_responder.sv
// spi_mem_responder: SPI mode-0 serial SRAM responder (READ 0x03 / WRITE 0x02, 16-bit address,
// auto-increment) bridging to a byte-wide synchronous memory port.
module spi_mem_responder
    import jrb8_spi_pkg::*;
#(
    parameter int ADDR_WIDTH  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  sclk,
    input  logic                  cs_n,
    input  logic                  mosi,
    output logic                  miso,
    output logic                  miso_oe,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_re,
    input  logic [7:0]            mem_rdata,
    output logic                  mem_we,
    output logic [7:0]            mem_wdata,
    output logic                  busy
);

    logic sclk_s, sclk_rise, sclk_fall;
    logic cs_s, cs_rise, cs_fall;
    logic [SYNC_STAGES-1:0] mosi_q;

    spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sclk (
        .clk(clk), .rst_n(rst_n), .d(sclk), .q(sclk_s), .rise(sclk_rise), .fall(sclk_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES)) u_cs (
        .clk(clk), .rst_n(rst_n), .d(cs_n), .q(cs_s), .rise(cs_rise), .fall(cs_fall)
    );

    spi_resp_state_t state_q, state_d;
    logic        rd_q, rd_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [6:0]  rx_q, rx_d;
    logic [7:0]  tx_q, tx_d;
    logic        oe_q, oe_d;
    logic [15:0] addr_q, addr_d;
    logic        re_q, re_d;
    logic        we_q, we_d;
    logic [7:0]  wdata_q, wdata_d;
    logic        pend_q, pend_d;
    logic        armed_q, armed_d;

    wire [7:0] rx_nx = {rx_q, mosi_q[SYNC_STAGES-1]};
    wire       done  = sclk_rise && cnt_q == 3'd7;

    always_comb begin
        state_d = state_q;
        rd_d    = rd_q;
        cnt_d   = cnt_q;
        rx_d    = rx_q;
        tx_d    = tx_q;
        oe_d    = oe_q;
        addr_d  = we_q ? addr_q + 16'd1 : addr_q;
        re_d    = 1'b0;
        we_d    = 1'b0;
        wdata_d = wdata_q;
        pend_d  = re_q && state_q == READ_DATA;
        // a fresh transaction needs an idle bus (cs_n high, sclk low) seen since reset
        armed_d = armed_q | (cs_s & ~sclk_s);
        if (cs_rise) begin
            state_d = IDLE;
            cnt_d   = 3'd0;
            tx_d    = 8'd0;
            oe_d    = 1'b0;
            pend_d  = 1'b0;
        end else if (state_q == IDLE) begin
            if (cs_fall && armed_q) begin
                state_d = CMD;
                cnt_d   = 3'd0;
            end
        end else begin
            if (sclk_rise) begin
                rx_d  = rx_nx[6:0];
                cnt_d = cnt_q + 3'd1;
            end
            // the fall right after a byte boundary must not shift: a fresh byte is being loaded
            if (pend_q) begin
                tx_d = mem_rdata;
                oe_d = 1'b1;
            end else if (sclk_fall && state_q == READ_DATA && cnt_q != 3'd0) begin
                tx_d = {tx_q[6:0], 1'b0};
            end
            if (done) begin
                case (state_q)
                    CMD: begin
                        rd_d    = rx_nx == CMD_READ;
                        state_d = (rx_nx == CMD_READ || rx_nx == CMD_WRITE) ? ADDR_HI : IGNORE;
                    end
                    ADDR_HI: begin
                        addr_d[15:8] = rx_nx;
                        state_d      = ADDR_LO;
                    end
                    ADDR_LO: begin
                        addr_d[7:0] = rx_nx;
                        re_d        = rd_q;
                        state_d     = rd_q ? READ_DATA : WRITE_DATA;
                    end
                    READ_DATA: begin
                        addr_d = addr_q + 16'd1;
                        re_d   = 1'b1;
                    end
                    WRITE_DATA: begin
                        we_d    = 1'b1;
                        wdata_d = rx_nx;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rd_q    <= 1'b0;
            cnt_q   <= 3'd0;
            rx_q    <= 7'd0;
            tx_q    <= 8'd0;
            oe_q    <= 1'b0;
            addr_q  <= 16'd0;
            re_q    <= 1'b0;
            we_q    <= 1'b0;
            wdata_q <= 8'd0;
            pend_q  <= 1'b0;
            armed_q <= 1'b0;
            mosi_q  <= '0;
        end else begin
            state_q <= state_d;
            rd_q    <= rd_d;
            cnt_q   <= cnt_d;
            rx_q    <= rx_d;
            tx_q    <= tx_d;
            oe_q    <= oe_d;
            addr_q  <= addr_d;
            re_q    <= re_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            pend_q  <= pend_d;
            armed_q <= armed_d;
            mosi_q  <= (mosi_q << 1) | SYNC_STAGES'(mosi);
        end
    end

    assign miso      = tx_q[7];
    assign miso_oe   = oe_q;
    assign mem_addr  = addr_q[ADDR_WIDTH-1:0];
    assign mem_re    = re_q;
    assign mem_we    = we_q;
    assign mem_wdata = wdata_q;
    assign busy      = ~cs_s & armed_q;

endmodule

// File: tb/tb_spi_mem_responder.sv
// tb_spi_mem_responder: directed SPI master with a scoreboard checking memory strobes and miso bytes.
module tb_spi_mem_responder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sclk = 1'b0;
    logic        cs_n = 1'b1;
    logic        mosi = 1'b0;
    logic        miso, miso_oe, mem_re, mem_we, busy;
    logic [15:0] mem_addr;
    logic [7:0]  mem_rdata = 8'd0;
    logic [7:0]  mem_wdata;

    int total = 0;
    int bad = 0;

    logic [15:0] exp_re[$];
    logic [23:0] exp_we[$];
    logic [7:0]  exp_rd[$];
    logic        exp_oe = 1'b0;
    logic [7:0]  mem [0:65535];
    logic [7:0]  sh = 8'd0;
    int          nb = 0;

    spi_mem_responder #(.ADDR_WIDTH(16), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
        .miso(miso), .miso_oe(miso_oe), .mem_addr(mem_addr), .mem_re(mem_re),
        .mem_rdata(mem_rdata), .mem_we(mem_we), .mem_wdata(mem_wdata), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_re) mem_rdata <= mem[mem_addr];
        if (mem_we) mem[mem_addr] <= mem_wdata;
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic unexpected(input string name, input logic [31:0] got);
        total++;
        bad++;
        $display("FAIL %s: got unexpected %0h with nothing expected at %0t", name, got, $time);
    endtask

    // memory strobe monitor
    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_re && mem_we) unexpected("re_we_overlap", {mem_addr, mem_wdata});
            if (mem_re) begin
                if (exp_re.size() == 0) unexpected("re_extra", mem_addr);
                else chk("re_addr", mem_addr, exp_re.pop_front());
            end
            if (mem_we) begin
                if (exp_we.size() == 0) unexpected("we_extra", {mem_addr, mem_wdata});
                else chk("we_addr_data", {mem_addr, mem_wdata}, exp_we.pop_front());
            end
        end
    end

    // miso monitor: samples like the master, on each sclk rise
    always @(posedge sclk) begin
        if (!cs_n && rst_n) begin
            chk("miso_oe", miso_oe, exp_oe);
            if (exp_oe) begin
                sh = {sh[6:0], miso};
                nb++;
                if (nb == 8) begin
                    nb = 0;
                    if (exp_rd.size() == 0) unexpected("rd_extra", sh);
                    else chk("rd_byte", sh, exp_rd.pop_front());
                end
            end
        end
    end

    always @(posedge cs_n) nb = 0;

    task automatic spi_bits(input logic [7:0] b, input int n);
        for (int i = 7; i > 7 - n; i--) begin
            mosi = b[i];
            #80 sclk = 1'b1;
            #80 sclk = 1'b0;
        end
    endtask

    task automatic cs_lo();
        @(negedge clk);
        cs_n = 1'b0;
        #160;
    endtask

    task automatic cs_hi();
        #80 cs_n = 1'b1;
        exp_oe = 1'b0;
        #300;
    endtask

    task automatic spi_read(input logic [15:0] a, input int n);
        cs_lo();
        spi_bits(8'h03, 8);
        spi_bits(a[15:8], 8);
        spi_bits(a[7:0], 8);
        exp_oe = 1'b1;
        for (int i = 0; i < n; i++) spi_bits(8'h00, 8);
        cs_hi();
    endtask

    initial begin
        mem[16'h1234] = 8'hA5;
        mem[16'h00FE] = 8'h11;
        mem[16'h00FF] = 8'h22;
        mem[16'h0100] = 8'h33;
        #33;
        chk("rst_miso", miso, 1'b0);
        chk("rst_oe", miso_oe, 1'b0);
        chk("rst_re", mem_re, 1'b0);
        chk("rst_we", mem_we, 1'b0);
        chk("rst_addr", mem_addr, 16'h0000);
        chk("rst_busy", busy, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        #200;
        chk("idle_busy", busy, 1'b0);

        // single-byte read; prefetch of the next address fires at byte end
        exp_re.push_back(16'h1234);
        exp_re.push_back(16'h1235);
        exp_rd.push_back(8'hA5);
        spi_read(16'h1234, 1);
        chk("read1_busy_after", busy, 1'b0);
        chk("read1_oe_after", miso_oe, 1'b0);

        // sequential read across a page boundary
        exp_re.push_back(16'h00FE);
        exp_re.push_back(16'h00FF);
        exp_re.push_back(16'h0100);
        exp_re.push_back(16'h0101);
        exp_rd.push_back(8'h11);
        exp_rd.push_back(8'h22);
        exp_rd.push_back(8'h33);
        spi_read(16'h00FE, 3);

        // write with address wrap at 0xFFFF
        exp_we.push_back({16'hFFFF, 8'h5A});
        exp_we.push_back({16'h0000, 8'hC3});
        cs_lo();
        chk("write_busy", busy, 1'b1);
        spi_bits(8'h02, 8);
        spi_bits(8'hFF, 8);
        spi_bits(8'hFF, 8);
        spi_bits(8'h5A, 8);
        spi_bits(8'hC3, 8);
        cs_hi();
        chk("write_wrap_mem0", mem[16'h0000], 8'hC3);

        // aborted second write byte: only the complete byte lands
        exp_we.push_back({16'h0040, 8'h77});
        cs_lo();
        spi_bits(8'h02, 8);
        spi_bits(8'h00, 8);
        spi_bits(8'h40, 8);
        spi_bits(8'h77, 8);
        spi_bits(8'hE8, 5);
        cs_hi();
        chk("abort_busy", busy, 1'b0);
        chk("abort_mem41", mem[16'h0041] === 8'hE8, 1'b0);
        exp_re.push_back(16'h0040);
        exp_re.push_back(16'h0041);
        exp_rd.push_back(8'h77);
        spi_read(16'h0040, 1);

        // unknown command is ignored
        cs_lo();
        spi_bits(8'h9F, 8);
        spi_bits(8'h12, 8);
        spi_bits(8'h34, 8);
        spi_bits(8'h56, 8);
        chk("ignore_busy", busy, 1'b1);
        chk("ignore_oe", miso_oe, 1'b0);
        cs_hi();
        chk("ignore_busy_after", busy, 1'b0);

        // reset pulsed in the middle of a read data byte
        exp_re.push_back(16'h1234);
        cs_lo();
        spi_bits(8'h03, 8);
        spi_bits(8'h12, 8);
        spi_bits(8'h34, 8);
        exp_oe = 1'b1;
        spi_bits(8'h00, 3);
        #40 rst_n = 1'b0;
        #1;
        chk("mid_rst_miso", miso, 1'b0);
        chk("mid_rst_oe", miso_oe, 1'b0);
        chk("mid_rst_re", mem_re, 1'b0);
        chk("mid_rst_addr", mem_addr, 16'h0000);
        chk("mid_rst_busy", busy, 1'b0);
        exp_oe = 1'b0;
        cs_n = 1'b1;
        #100;
        @(negedge clk);
        rst_n = 1'b1;
        #300;
        exp_re.push_back(16'h00FE);
        exp_re.push_back(16'h00FF);
        exp_rd.push_back(8'h11);
        spi_read(16'h00FE, 1);

        #500;
        chk("left_re", exp_re.size(), 0);
        chk("left_we", exp_we.size(), 0);
        chk("left_rd", exp_rd.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
